serial_borrow_subtractor: RTL and testbench
===========================================

Name: serial_borrow_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
- It is the inverse operation of the team's combinational ripple carry adder.
- Used where area matters more than latency; shares the adder's operand/flag conventions (a, b, carry/borrow in/out).
- Start/ready/done handshake; results held until the next operation.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous reset, active-high
- start  input   1      request a subtraction; sampled only when ready=1
- a      input   WIDTH  minuend; sampled with start
- b      input   WIDTH  subtrahend; sampled with start
- bin    input   1      borrow-in; sampled with start
- ready  output  1      high in IDLE; block can accept start
- busy   output  1      high while bits are being processed (= ~ready)
- done   output  1      one-cycle pulse when diff/bout are updated
- diff   output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout   output  1      borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, bit counter and borrow flop cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a, b and bin into a_sh, b_sh and the borrow flop; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - ready=0, busy=1. One bit per edge:
    - d = a_sh[0] ^ b_sh[0] ^ brw
    - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
    - d shifts into the MSB of the result shift register; a_sh and b_sh shift right; counter increments.
  - On the edge processing bit WIDTH-1: diff <= full result, bout <= brw_next, done <= 1, state <= IDLE.
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH; done=1 during the cycle after E_WIDTH. Total WIDTH+1 edges from start to the done cycle.
- done:
  - Exactly one cycle wide; cleared on the next edge.
  - Only updates diff/bout; they hold otherwise and are never partially updated mid-RUN.
- start while busy: ignored, with no effect on the operation in progress or on its latched operands.
- start high in the done cycle: accepted, because state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- start held continuously: a new operation begins every WIDTH+1 cycles with freshly sampled operands.
- a, b and bin may change freely after the start edge.
- Arithmetic is unsigned, modulo 2^WIDTH:
  - a=0, b=2^WIDTH-1, bin=1 gives diff=0, bout=1.
  - a=b, bin=0 gives diff=0, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, updated together with diff in the done cycle.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands; two's-complement overflow of a - b - bin.
- Not defined:
  - Port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=0101, b=0011, bin=0, one-cycle start: ready drops after start edge, done pulses on the WIDTH+1 edge, diff=0010, bout=0, ready=1 in the done cycle.
- a=0000, b=0001, bin=0 -> diff=1111, bout=1; then a=1001, b=0110, bin=1 -> diff=0010, bout=0; diff holds 1111 until the second done.
- Edge cases: a=0000, b=1111, bin=1 -> diff=0000, bout=1; a=1111, b=1111, bin=0 -> diff=0000, bout=0.
- start pulsed twice during RUN with different operands -> ignored; result matches the first operands; exactly one done pulse.
- Back-to-back: start held high for 3 operations -> 3 done pulses spaced WIDTH+1 cycles apart, correct results each time.
- rst asserted asynchronously mid-RUN (after 2 bits) -> outputs immediately return to reset values; no done pulse; a following operation (0111-0010) gives diff=0101.
- SERIAL_SUB_SIGNED_OVF_EN defined: 1000-0001 gives ovf=1, diff=0111; 0111-0001 gives ovf=0.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_borrow_subtractor
// Purpose : Bit-serial ripple-borrow subtractor, diff = a - b - bin, LSB first,
//           with start/ready/done handshake. Optional signed-overflow flag
//           enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             bit_d;
    logic             brw_d;
    logic [WIDTH-1:0] res_d;

    // One full-subtractor cell applied to the current LSBs.
    assign bit_d = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    assign brw_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        brw_q   <= bin_i;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    brw_q  <= brw_d;
                    cnt_q  <= cnt_q + CW'(1);
                    // Results are published only once all bits are in.
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= brw_d;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = (state_q == S_RUN);
    assign done_o  = done_q;
    assign diff_o  = diff_q;
    assign bout_o  = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_borrow_subtractor
// Purpose : Directed-vector bench for serial_borrow_subtractor with an
//           arithmetic reference model compared every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_borrow_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             bout_o;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf_o;
`endif

    int n_vec = 0;
    int n_bad = 0;

    serial_borrow_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .bin_i   (bin_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .bout_o  (bout_o)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result is plain integer arithmetic, delivered WIDTH+1 edges after start.
    logic             m_busy;
    int               m_left;
    logic             m_done;
    logic [WIDTH-1:0] m_diff;
    logic             m_bout;
    logic             m_ovf;
    logic [WIDTH-1:0] m_pa;
    logic [WIDTH-1:0] m_pb;
    logic             m_pbin;

    function automatic int to_signed(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
    endfunction

    function automatic logic [WIDTH+1:0] ref_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic bin);
        int u;
        int s;
        logic [WIDTH-1:0] d;
        u = int'(a) - int'(b) - int'(bin);
        s = to_signed(a) - to_signed(b) - int'(bin);
        d = u[WIDTH-1:0];
        return {(s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1))), u < 0, d};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
            m_pa   <= '0;
            m_pb   <= '0;
            m_pbin <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start_i) begin
                    m_busy <= 1'b1;
                    m_left <= WIDTH;
                    m_pa   <= a_i;
                    m_pb   <= b_i;
                    m_pbin <= bin_i;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_ovf, m_bout, m_diff} <= ref_sub(m_pa, m_pb, m_pbin);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(ready_o), 32'(!m_busy));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("done", 32'(done_o), 32'(m_done));
        chk("diff", 32'(diff_o), 32'(m_diff));
        chk("bout", 32'(bout_o), 32'(m_bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
`endif
    end

    // One-cycle start, then check latency, held result and literal outcome.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input logic [WIDTH-1:0] exp_d, input logic exp_b,
                         input logic [WIDTH-1:0] hold_d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        start_i = 1'b1; a_i = a; b_i = b; bin_i = bin;
        for (int n = 1; n <= WIDTH + 3 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("ready_drop", 32'(ready_o), 32'd0);
                start_i = 1'b0; a_i = ~a; b_i = ~b; bin_i = ~bin;
            end
            if (done_o) begin
                got = 1'b1;
                chk("latency", 32'(n), 32'(WIDTH + 1));
                chk("lit_diff", 32'(diff_o), 32'(exp_d));
                chk("lit_bout", 32'(bout_o), 32'(exp_b));
                chk("lit_ready", 32'(ready_o), 32'd1);
                chk("model_diff", 32'(m_diff), 32'(exp_d));
            end else begin
                chk("diff_hold", 32'(diff_o), 32'(hold_d));
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] bb_a [3] = '{4'b1001, 4'b0010, 4'b1111};
        logic [WIDTH-1:0] bb_b [3] = '{4'b0011, 4'b0111, 4'b0000};
        logic             bb_c [3] = '{1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] bb_d [3] = '{4'b0110, 4'b1010, 4'b1110};
        logic             bb_o [3] = '{1'b0, 1'b1, 1'b0};
        int cnt;
        int dones;

        rst = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_diff", 32'(diff_o), 32'd0);
        #2 rst = 1'b0;

        do_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 4'b0000);
        do_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 4'b0010);
        do_op(4'b1001, 4'b0110, 1'b1, 4'b0010, 1'b0, 4'b1111);
        do_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0010);
        do_op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // start pulsed twice during RUN must be ignored
        @(negedge clk);
        start_i = 1'b1; a_i = 4'b0101; b_i = 4'b0011; bin_i = 1'b0;
        dones = 0;
        for (int n = 1; n <= 2 * WIDTH + 2; n++) begin
            @(negedge clk);
            case (n)
                1: begin start_i = 1'b1; a_i = 4'b1111; b_i = 4'b0000; bin_i = 1'b1; end
                2: start_i = 1'b0;
                3: begin start_i = 1'b1; a_i = 4'b1110; b_i = 4'b0001; end
                default: start_i = 1'b0;
            endcase
            if (done_o) begin
                dones++;
                chk("ign_diff", 32'(diff_o), 32'b0010);
                chk("ign_bout", 32'(bout_o), 32'd0);
            end
        end
        chk("ign_done_count", 32'(dones), 32'd1);

        // start held high: three operations back to back
        @(negedge clk);
        start_i = 1'b1; a_i = bb_a[0]; b_i = bb_b[0]; bin_i = bb_c[0];
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done_o && cnt < WIDTH + 3);
            chk("b2b_spacing", 32'(cnt), 32'(WIDTH + 1));
            chk("b2b_diff", 32'(diff_o), 32'(bb_d[k]));
            chk("b2b_bout", 32'(bout_o), 32'(bb_o[k]));
            if (k < 2) begin
                a_i = bb_a[k+1]; b_i = bb_b[k+1]; bin_i = bb_c[k+1];
            end else begin
                start_i = 1'b0;
            end
        end

        // asynchronous reset after two bits have been processed
        @(negedge clk);
        start_i = 1'b1; a_i = 4'b1100; b_i = 4'b0001; bin_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_diff", 32'(diff_o), 32'd0);
        chk("arst_bout", 32'(bout_o), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 2 * WIDTH; n++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        do_op(4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, 4'b0000);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
        do_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 4'b0101);
        chk("lit_ovf_set", 32'(ovf_o), 32'd1);
        do_op(4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0, 4'b0111);
        chk("lit_ovf_clr", 32'(ovf_o), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
